// File: rtl/ser2par_pkg.sv
// Shared constants for the serial-to-parallel CDC converter.
package ser2par_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int WIDTH_MIN       = 2;

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchroniser chain with asynchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ser2par_cdc.sv
// Serial capture on clka, toggle req/ack handshake, parallel word delivery on clkb.
module ser2par_cdc
    import ser2par_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             clkb,
    input  logic             wra_n,
    input  logic             din,
    output logic             busy_a,
    output logic             ovf_a,
    output logic             wrb,
    output logic [WIDTH-1:0] db_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN) begin : g_bad_width
        $error("ser2par_cdc: WIDTH below minimum");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
        $error("ser2par_cdc: SYNC_STAGES below minimum");
    end

    // Per-domain reset: asserted asynchronously, released synchronously.
    logic [1:0] rst_a_q;
    logic [1:0] rst_b_q;
    logic       rst_a_n;
    logic       rst_b_n;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rst_a_q <= '0;
        end else begin
            rst_a_q <= {rst_a_q[0], 1'b1};
        end
    end

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            rst_b_q <= '0;
        end else begin
            rst_b_q <= {rst_b_q[0], 1'b1};
        end
    end

    assign rst_a_n = rst_a_q[1];
    assign rst_b_n = rst_b_q[1];

    // sh keeps only the WIDTH-1 earlier bits; the current din completes the word.
    logic [WIDTH-2:0] sh;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    bit_cnt;
    logic             req_t;
    logic             ack_t;
    logic             ack_sync;
    logic             req_s;
    logic             req_d;

    if (MSB_FIRST != 0) begin : g_msb
        assign word_next = {sh, din};
    end else begin : g_lsb
        assign word_next = {din, sh};
    end

    assign busy_a = req_t ^ ack_sync;

    always_ff @(posedge clka or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sh      <= '0;
            bit_cnt <= '0;
            hold    <= '0;
            req_t   <= 1'b0;
            ovf_a   <= 1'b0;
        end else begin
            ovf_a <= 1'b0;
            if (wra_n) begin
                bit_cnt <= '0;
            end else begin
                if (MSB_FIRST != 0) begin
                    sh <= word_next[WIDTH-2:0];
                end else begin
                    sh <= word_next[WIDTH-1:1];
                end
                if (bit_cnt == LAST) begin
                    bit_cnt <= '0;
                    if (busy_a) begin
                        ovf_a <= 1'b1;
                    end else begin
                        hold  <= word_next;
                        req_t <= ~req_t;
                    end
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clkb),
        .rst_n (rst_b_n),
        .d     (req_t),
        .q     (req_s)
    );

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clka),
        .rst_n (rst_a_n),
        .d     (ack_t),
        .q     (ack_sync)
    );

    // hold is static whenever req_s differs from req_d, so the wide capture is safe.
    always_ff @(posedge clkb or negedge rst_b_n) begin
        if (!rst_b_n) begin
            req_d  <= 1'b0;
            wrb    <= 1'b0;
            db_out <= '0;
        end else begin
            req_d <= req_s;
            wrb   <= req_s ^ req_d;
            if (req_s ^ req_d) begin
                db_out <= hold;
            end
        end
    end

    assign ack_t = req_d;

endmodule
